// File: rtl/lr_pkg.sv
// Shared constants and FSM encoding for the 9x9 line-buffer window and the
// inner-product stages that consume its window.
package lr_pkg;

  localparam int PIX_W     = 7;
  localparam int WIN       = 9;
  localparam int WIN_ELEMS = WIN * WIN;
  localparam int WINDOW_W  = WIN_ELEMS * PIX_W;
  localparam int LINES     = WIN - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit offset of window element (row, col); row 0 is the oldest line.
  function automatic int elem_lsb(input int row, input int col);
    return (row * WIN + col) * PIX_W;
  endfunction

endpackage

// File: rtl/linebuffer_window9_line_delay.sv
// One image line of delay: a ring buffer that advances only on accepted
// pixels, so dout_o is the pixel accepted exactly DEPTH accepts earlier.
module line_delay #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;

  // Read-before-write at the same slot gives the full-line delay.
  assign dout_o = mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en_i) begin
      if (ptr_q == AW'(DEPTH - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/linebuffer_window9.sv
// Raster-order 9x9 sliding window over a 7-bit image using eight line delays;
// emits one registered window per pixel at x>=8, y>=8.
module linebuffer_window9
  import lr_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_valid,
  input  logic [PIX_W-1:0]    pix_in,
  input  logic                sof,
  output logic                win_valid,
  output logic [WINDOW_W-1:0] window,
  output logic [9:0]          win_x,
  output logic [9:0]          win_y,
  output logic                frame_done,
  output logic [1:0]          dbg_state
);

  // Handshake: pix_valid alone qualifies pix_in/sof (no ready, never stalls);
  // win_valid is a one-cycle qualifier for window/win_x/win_y, sampled then.
  state_e              state_q;
  logic [9:0]          x_q, y_q;
  logic [WINDOW_W-1:0] window_q, window_d;
  logic                win_valid_q, frame_done_q;
  logic [9:0]          win_x_q, win_y_q;

  logic                sof_acc, accept, row_end;
  logic [9:0]          cur_x, cur_y, nxt_x, nxt_y;
  logic [PIX_W-1:0]    line_in  [LINES];
  logic [PIX_W-1:0]    line_out [LINES];
  logic [PIX_W-1:0]    col_in   [WIN];

  assign line_in[0] = pix_in;

  for (genvar i = 1; i < LINES; i++) begin : g_chain
    assign line_in[i] = line_out[i-1];
  end

  for (genvar i = 0; i < LINES; i++) begin : g_line
    line_delay #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIX_W)
    ) u_line (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (accept),
      .din_i  (line_in[i]),
      .dout_o (line_out[i])
    );
  end

  always_comb begin
    sof_acc = pix_valid && sof;
    accept  = sof_acc || (pix_valid && (state_q == ST_FILL || state_q == ST_ACTIVE));
    cur_x   = sof_acc ? 10'd0 : x_q;
    cur_y   = sof_acc ? 10'd0 : y_q;
    row_end = (cur_x == 10'(IMG_WIDTH - 1));
    nxt_x   = row_end ? 10'd0 : cur_x + 10'd1;
    nxt_y   = row_end ? cur_y + 10'd1 : cur_y;
  end

  // Row 0 (oldest) comes from the deepest line; row 8 is the live pixel.
  always_comb begin
    col_in[WIN-1] = pix_in;
    for (int r = 0; r < WIN - 1; r++) begin
      col_in[r] = line_out[WIN-2-r];
    end
    window_d = window_q;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if (c < WIN - 1) begin
          window_d[elem_lsb(r, c) +: PIX_W] = window_q[elem_lsb(r, c + 1) +: PIX_W];
        end else begin
          window_d[elem_lsb(r, c) +: PIX_W] = col_in[r];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      window_q     <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept) begin
        x_q         <= nxt_x;
        y_q         <= nxt_y;
        window_q    <= window_d;
        win_x_q     <= cur_x;
        win_y_q     <= cur_y;
        win_valid_q <= (cur_x >= 10'd8) && (cur_y >= 10'd8);
        if (sof_acc) begin
          state_q <= ST_FILL;
        end else if (state_q == ST_FILL && row_end && cur_y == 10'd7) begin
          state_q <= ST_ACTIVE;
        end else if (state_q == ST_ACTIVE && row_end && cur_y == 10'(IMG_HEIGHT - 1)) begin
          state_q      <= ST_DONE;
          frame_done_q <= 1'b1;
        end
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign window     = window_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_linebuffer_window9.sv
// Directed bench for linebuffer_window9: ramp frames with and without gaps,
// mid-frame sof, mid-frame reset and post-frame pixel dropping.
module tb_linebuffer_window9;
  import lr_pkg::*;

  localparam int W = 28;
  localparam int H = 28;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                pix_valid = 1'b0;
  logic [PIX_W-1:0]    pix_in = '0;
  logic                sof = 1'b0;
  logic                win_valid, frame_done;
  logic [WINDOW_W-1:0] window;
  logic [9:0]          win_x, win_y;
  logic [1:0]          dbg_state;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  int win_cnt, done_cnt, bad_cnt, low_x_cnt;
  int first_x, first_y, first_e0, first_e80, wrap_e0;

  linebuffer_window9 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .sof        (sof),
    .win_valid  (win_valid),
    .window     (window),
    .win_x      (win_x),
    .win_y      (win_y),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PIX_W-1:0] ramp(input int x, input int y);
    return 7'((x + y) % 128);
  endfunction

  task automatic clear_stats();
    win_cnt   = 0;
    done_cnt  = 0;
    bad_cnt   = 0;
    low_x_cnt = 0;
    first_x   = -1;
    first_y   = -1;
    first_e0  = -1;
    first_e80 = -1;
    wrap_e0   = -1;
    exp_q.delete();
  endtask

  // ---------------- driver + scoreboard ----------------
  // acc says whether the bench expects the DUT to accept this pixel.
  task automatic send(input logic v, input int x, input int y, input logic s, input logic acc);
    logic        exp_win, exp_done;
    logic [19:0] c;
    int          ex, ey;
    logic [PIX_W-1:0] e;
    pix_valid = v;
    sof       = s;
    pix_in    = v ? ramp(x, y) : 7'($urandom_range(0, 127));
    exp_win   = v && acc && x >= 8 && y >= 8;
    exp_done  = v && acc && x == W - 1 && y == H - 1;
    if (exp_win) exp_q.push_back({10'(x), 10'(y)});
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    if (win_valid !== exp_win) bad_cnt++;
    if (frame_done !== exp_done) bad_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (win_valid === 1'b1) begin
      win_cnt++;
      if (win_x < 10'd8) low_x_cnt++;
      if (exp_q.size() == 0) begin
        bad_cnt++;
      end else begin
        c  = exp_q.pop_front();
        ex = int'(c[19:10]);
        ey = int'(c[9:0]);
        if (win_x !== c[19:10] || win_y !== c[9:0]) bad_cnt++;
        for (int r = 0; r < WIN; r++) begin
          for (int cc = 0; cc < WIN; cc++) begin
            e = window[(r * WIN + cc) * PIX_W +: PIX_W];
            if (e !== ramp(ex - 8 + cc, ey - 8 + r)) bad_cnt++;
          end
        end
        if (win_cnt == 1) begin
          first_x   = int'(win_x);
          first_y   = int'(win_y);
          first_e0  = int'(window[6:0]);
          first_e80 = int'(window[80 * PIX_W +: PIX_W]);
        end
        if (ex == 8 && ey == 9) wrap_e0 = int'(window[6:0]);
      end
    end
  endtask

  // Sends a ramp frame from (0,0) with sof, stopping before (stop_x, stop_y).
  task automatic send_frame(input int gap_pct, input int stop_x, input int stop_y);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (x == stop_x && y == stop_y) return;
        if (gap_pct > 0) begin
          while ($urandom_range(0, 99) < gap_pct) send(1'b0, 0, 0, 1'b0, 1'b0);
        end
        send(1'b1, x, y, (x == 0 && y == 0), 1'b1);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %0b want 0", win_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
    checks++; if (window !== '0) begin errors++; $display("FAIL reset_window: got %h want 0", window); end
    checks++; if (win_x !== 10'd0 || win_y !== 10'd0) begin errors++; $display("FAIL reset_coords: got (%0d,%0d) want (0,0)", win_x, win_y); end
    checks++; if (dbg_state !== 2'(ST_IDLE)) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 10; i++) send(1'b1, i, 0, 1'b0, 1'b0);
    checks++; if (win_cnt !== 0 || bad_cnt !== 0) begin errors++; $display("FAIL idle_no_sof: got %0d windows %0d bad want 0 0", win_cnt, bad_cnt); end
  endtask

  task automatic test_ramp();
    clear_stats();
    send_frame(0, -1, -1);
    checks++; if (win_cnt !== 400) begin errors++; $display("FAIL ramp_count: got %0d want 400", win_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ramp_done: got %0d want 1", done_cnt); end
    checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL ramp_content: got %0d bad cycles want 0", bad_cnt); end
    checks++; if (first_x !== 8 || first_y !== 8) begin errors++; $display("FAIL ramp_first_xy: got (%0d,%0d) want (8,8)", first_x, first_y); end
    checks++; if (first_e0 !== 0) begin errors++; $display("FAIL ramp_first_e0: got %0d want 0", first_e0); end
    checks++; if (first_e80 !== 16) begin errors++; $display("FAIL ramp_first_e80: got %0d want 16", first_e80); end
    checks++; if (dbg_state !== 2'(ST_DONE)) begin errors++; $display("FAIL ramp_state: got %0d want %0d", dbg_state, ST_DONE); end
  endtask

  task automatic test_row_wrap();
    clear_stats();
    send_frame(0, -1, -1);
    checks++; if (low_x_cnt !== 0) begin errors++; $display("FAIL wrap_low_x: got %0d windows with x<8 want 0", low_x_cnt); end
    checks++; if (wrap_e0 !== 1) begin errors++; $display("FAIL wrap_e0_at_8_9: got %0d want 1", wrap_e0); end
    checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL wrap_content: got %0d bad cycles want 0", bad_cnt); end
  endtask

  task automatic test_gaps();
    clear_stats();
    send_frame(50, -1, -1);
    checks++; if (win_cnt !== 400) begin errors++; $display("FAIL gaps_count: got %0d want 400", win_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL gaps_done: got %0d want 1", done_cnt); end
    checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL gaps_content: got %0d bad cycles want 0", bad_cnt); end
  endtask

  task automatic test_sof_restart();
    clear_stats();
    send_frame(0, 5, 12);
    checks++; if (bad_cnt !== 0 || win_cnt == 0) begin errors++; $display("FAIL sof_partial: got %0d bad %0d windows want 0 bad", bad_cnt, win_cnt); end
    clear_stats();
    send_frame(0, -1, -1);
    checks++; if (first_x !== 8 || first_y !== 8) begin errors++; $display("FAIL sof_first_xy: got (%0d,%0d) want (8,8)", first_x, first_y); end
    checks++; if (win_cnt !== 400 || done_cnt !== 1) begin errors++; $display("FAIL sof_counts: got %0d windows %0d done want 400 1", win_cnt, done_cnt); end
    checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL sof_content: got %0d bad cycles want 0", bad_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    send_frame(0, 16, 15);
    checks++; if (win_valid !== 1'b1 || bad_cnt !== 0) begin errors++; $display("FAIL rstmid_pre: got valid %0b bad %0d want 1 0", win_valid, bad_cnt); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (win_valid !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got %0b %0b want 0 0", win_valid, frame_done); end
    checks++; if (window !== '0 || win_x !== 10'd0 || win_y !== 10'd0) begin errors++; $display("FAIL rstmid_data: got (%0d,%0d) window %h want zeros", win_x, win_y, window); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 30; i++) send(1'b1, 16 + (i % 12), 15, 1'b0, 1'b0);
    checks++; if (win_cnt !== 0 || bad_cnt !== 0) begin errors++; $display("FAIL rstmid_ignore: got %0d windows %0d bad want 0 0", win_cnt, bad_cnt); end
    clear_stats();
    send_frame(0, -1, -1);
    checks++; if (win_cnt !== 400 || bad_cnt !== 0 || done_cnt !== 1) begin errors++; $display("FAIL rstmid_frame: got %0d windows %0d bad %0d done want 400 0 1", win_cnt, bad_cnt, done_cnt); end
  endtask

  task automatic test_after_done();
    clear_stats();
    for (int i = 0; i < 50; i++) send(1'b1, i % W, H - 1, 1'b0, 1'b0);
    checks++; if (win_cnt !== 0) begin errors++; $display("FAIL done_drop_win: got %0d want 0", win_cnt); end
    checks++; if (done_cnt !== 0 || bad_cnt !== 0) begin errors++; $display("FAIL done_drop_flags: got %0d done %0d bad want 0 0", done_cnt, bad_cnt); end
    checks++; if (dbg_state !== 2'(ST_DONE)) begin errors++; $display("FAIL done_state: got %0d want %0d", dbg_state, ST_DONE); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_stats();
    test_reset();
    test_ramp();
    test_row_wrap();
    test_gaps();
    test_sof_restart();
    test_after_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
